// File: rtl/mux4_rr_sched_pkg.sv
// Shared definitions for the 4:1 round-robin flit scheduler.
//   NUM_REQ    - number of requesters sharing the output port
//   SEL_W      - width of the mux select / requester index
//   DEF_DATA_W - default flit width
//   state_t    - scheduler state (IDLE arbitrates, LOCK holds the port for a packet)
package mux4_rr_sched_pkg;

   localparam int NUM_REQ    = 4;
   localparam int SEL_W      = 2;
   localparam int DEF_DATA_W = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

endpackage

// File: rtl/mux4_rr_sched_pick.sv
// rr_pick4: combinational 4-way rotating priority encoder.
//   req - request vector
//   ptr - requester with highest priority this cycle
//   any - at least one request is present
//   idx - first requesting index scanning ptr, ptr+1, ... modulo 4;
//         equals ptr when nothing is requesting
module rr_pick4
   import mux4_rr_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               any,
   output logic [SEL_W-1:0]   idx
);

   logic [SEL_W-1:0] cand;

   assign any = |req;

   // Scan from the farthest offset back towards ptr so the closest
   // requester (lowest rotated offset) is the last one to overwrite idx.
   always_comb begin
      idx  = ptr;
      cand = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) begin
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/mux4to1.sv
// Single-bit 4:1 mux cell used as one slice of the flit datapath.
//   sel - select index (0..3)
//   d   - the four candidate bits, d[i] is requester i
//   y   - selected bit
module mux4to1 (
   input  logic [1:0] sel,
   input  logic [3:0] d,
   output logic       y
);

   assign y = d[sel];

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler for a 4:1 flit mux with optional packet locking
// and a one-entry registered output slot.
//   clk, rst_n          - clock, asynchronous active-low reset
//   req, in_last        - per-requester flit valid / tail marker
//   in_data_0..3        - per-requester flit
//   gnt                 - one-hot accept; transfer when req[i] & gnt[i]
//   sel                 - current winner, drives the mux4to1 slice selects
//   out_valid/data/last - output slot contents
//   out_ready           - downstream accepts the slot this cycle
//   busy                - a packet currently owns the port
module mux4_rr_sched
   import mux4_rr_sched_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter bit LOCK_PKT = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [DATA_W-1:0]    in_data_0,
   input  logic [DATA_W-1:0]    in_data_1,
   input  logic [DATA_W-1:0]    in_data_2,
   input  logic [DATA_W-1:0]    in_data_3,
   input  logic [NUM_REQ-1:0]   in_last,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [SEL_W-1:0]     sel,
   output logic                 out_valid,
   output logic [DATA_W-1:0]    out_data,
   output logic                 out_last,
   input  logic                 out_ready,
   output logic                 busy
);

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   ptr, ptr_nxt;
   logic [SEL_W-1:0]   owner, owner_nxt;
   logic               pick_any;
   logic [SEL_W-1:0]   pick_idx;
   logic [SEL_W-1:0]   winner;
   logic               can_acc;
   logic               xfer;
   logic [DATA_W-1:0]  mux_data;
   logic               mux_last;

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   // The slot can take a new flit when empty or when it drains this cycle.
   assign can_acc = !out_valid || out_ready;

   // Bit-sliced datapath: one mux cell per data bit plus one for the tail marker.
   for (genvar b = 0; b < DATA_W; b++) begin : g_bit
      mux4to1 u_mux (
         .sel (sel),
         .d   ({in_data_3[b], in_data_2[b], in_data_1[b], in_data_0[b]}),
         .y   (mux_data[b])
      );
   end

   mux4to1 u_mux_last (
      .sel (sel),
      .d   (in_last),
      .y   (mux_last)
   );

   // Grant and next-state logic. Grants are forced off while reset is held
   // so an upstream requester cannot see an accept it would never complete.
   // In LOCK only the owner may be granted, even when it is not requesting.
   always_comb begin
      winner    = pick_idx;
      gnt       = '0;
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      if (state == ST_LOCK) begin
         winner = owner;
      end
      if (rst_n && can_acc) begin
         if (state == ST_IDLE) begin
            if (pick_any) begin
               gnt[winner] = 1'b1;
            end
         end else begin
            gnt[owner] = req[owner];
         end
      end
      xfer = |(req & gnt);
      if (xfer) begin
         if (state == ST_IDLE) begin
            ptr_nxt = winner + SEL_W'(1);
            if (LOCK_PKT && !in_last[winner]) begin
               state_nxt = ST_LOCK;
               owner_nxt = winner;
            end
         end else if (in_last[owner]) begin
            state_nxt = ST_IDLE;
         end
      end
   end

   assign sel  = winner;
   assign busy = (state == ST_LOCK);

   // Arbitration state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         ptr   <= '0;
         owner <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
      end
   end

   // Output slot: load on transfer, empty on drain, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= mux_data;
         out_last  <= mux_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Self-checking bench for mux4_rr_sched: table-driven grant/select/busy
// vectors with a scoreboard for the registered output slot, plus hand
// sequences for backpressure and mid-packet reset.
module tb_mux4_rr_sched;

   localparam int DW = 16;

   logic          clk;
   logic          rst_n;
   logic [3:0]    req;
   logic [DW-1:0] in_data_0, in_data_1, in_data_2, in_data_3;
   logic [3:0]    in_last;
   logic          out_ready;

   logic [3:0]    gnt;
   logic [1:0]    sel;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;

   logic [3:0]    nl_gnt;
   logic [1:0]    nl_sel;
   logic          nl_out_valid;
   logic [DW-1:0] nl_out_data;
   logic          nl_out_last;
   logic          nl_busy;

   mux4_rr_sched #(.DATA_W(DW), .LOCK_PKT(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in_data_0 (in_data_0),
      .in_data_1 (in_data_1),
      .in_data_2 (in_data_2),
      .in_data_3 (in_data_3),
      .in_last   (in_last),
      .gnt       (gnt),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   mux4_rr_sched #(.DATA_W(DW), .LOCK_PKT(1'b0)) dut_nl (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in_data_0 (in_data_0),
      .in_data_1 (in_data_1),
      .in_data_2 (in_data_2),
      .in_data_3 (in_data_3),
      .in_last   (in_last),
      .gnt       (nl_gnt),
      .sel       (nl_sel),
      .out_valid (nl_out_valid),
      .out_data  (nl_out_data),
      .out_last  (nl_out_last),
      .out_ready (out_ready),
      .busy      (nl_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] req;
      logic [3:0] last;
      logic       rdy;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       nl;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   vec_t          tbl[$];
   exp_t          sb[$];
   int            n_vec  = 0;
   int            n_fail = 0;
   int            step_no = 0;
   logic [DW-1:0] exp_slot_data = '0;

   task automatic add(input string name, input logic [3:0] r, input logic [3:0] l,
                      input logic rdy, input logic [3:0] g, input logic [1:0] s,
                      input logic b, input logic nl);
      vec_t v;
      v.name = name; v.req = r; v.last = l; v.rdy = rdy;
      v.gnt = g; v.sel = s; v.busy = b; v.nl = nl;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s (step %0d): got %0h expected %0h", name, step_no, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] flit(input int k, input int s);
      return {4'(k), 12'(s)};
   endfunction

   // One cycle: check the slot loaded at the previous edge, drive new
   // inputs, then check the combinational grant away from the edge.
   task automatic step(input vec_t v);
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         exp_slot_data = e.data;
         check({v.name, ".out_valid"}, 32'(out_valid), 32'd1);
         check({v.name, ".out_data"},  32'(out_data),  32'(e.data));
         check({v.name, ".out_last"},  32'(out_last),  32'(e.last));
      end
      step_no++;
      req       = v.req;
      in_last   = v.last;
      out_ready = v.rdy;
      in_data_0 = flit(0, step_no);
      in_data_1 = flit(1, step_no);
      in_data_2 = flit(2, step_no);
      in_data_3 = flit(3, step_no);
      @(negedge clk);
      check({v.name, ".gnt"},  32'(gnt),  32'(v.gnt));
      check({v.name, ".sel"},  32'(sel),  32'(v.sel));
      check({v.name, ".busy"}, 32'(busy), 32'(v.busy));
      if (v.nl) begin
         check({v.name, ".nl_gnt"}, 32'(nl_gnt), 32'(v.gnt));
      end
      if (v.busy) begin
         check({v.name, ".nl_busy"}, 32'(nl_busy), 32'd0);
      end
      for (int k = 0; k < 4; k++) begin
         if (v.gnt[k]) begin
            e.data = flit(k, step_no);
            e.last = v.last[k];
            sb.push_back(e);
         end
      end
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         step(tbl[i]);
      end
   endtask

   int   a_end, b_end, c_end, d_end, e_end, f_end;
   vec_t hv;

   initial begin
      // Table of all vectors: name, req, last, ready, gnt, sel, busy, check-nl.
      add("rr0",   4'hF, 4'hF, 1, 4'b0001, 2'd0, 0, 1);
      add("rr1",   4'hF, 4'hF, 1, 4'b0010, 2'd1, 0, 1);
      add("rr2",   4'hF, 4'hF, 1, 4'b0100, 2'd2, 0, 1);
      add("rr3",   4'hF, 4'hF, 1, 4'b1000, 2'd3, 0, 1);
      add("rr4",   4'hF, 4'hF, 1, 4'b0001, 2'd0, 0, 1);
      a_end = tbl.size();
      add("pk_pre", 4'b0010, 4'hF, 1, 4'b0010, 2'd1, 0, 0);
      add("pk_f1",  4'hF, 4'h0, 1, 4'b0100, 2'd2, 0, 0);
      add("pk_f2",  4'hF, 4'h0, 1, 4'b0100, 2'd2, 1, 0);
      add("pk_f3",  4'hF, 4'b0100, 1, 4'b0100, 2'd2, 1, 0);
      add("pk_nx3", 4'hF, 4'hF, 1, 4'b1000, 2'd3, 0, 0);
      add("pk_nx0", 4'hF, 4'hF, 1, 4'b0001, 2'd0, 0, 0);
      b_end = tbl.size();
      add("og_f1",  4'b0010, 4'h0, 1, 4'b0010, 2'd1, 0, 0);
      add("og_gap1", 4'b1001, 4'h0, 1, 4'b0000, 2'd1, 1, 0);
      add("og_gap2", 4'b1001, 4'h0, 1, 4'b0000, 2'd1, 1, 0);
      add("og_f2",  4'b1011, 4'h0, 1, 4'b0010, 2'd1, 1, 0);
      add("og_f3",  4'b1011, 4'b0010, 1, 4'b0010, 2'd1, 1, 0);
      add("og_nxt", 4'b1001, 4'hF, 1, 4'b1000, 2'd3, 0, 0);
      c_end = tbl.size();
      add("wr_to3",  4'b0100, 4'hF, 1, 4'b0100, 2'd2, 0, 0);
      add("wr_wrap", 4'b0001, 4'hF, 1, 4'b0001, 2'd0, 0, 0);
      add("wr_ptr1", 4'b0011, 4'hF, 1, 4'b0010, 2'd1, 0, 0);
      add("wr_iso3", 4'b1000, 4'hF, 1, 4'b1000, 2'd3, 0, 0);
      add("wr_none", 4'b0000, 4'hF, 1, 4'b0000, 2'd0, 0, 0);
      d_end = tbl.size();
      add("mr_f1",  4'b0001, 4'h0, 1, 4'b0001, 2'd0, 0, 0);
      add("mr_f2",  4'hF, 4'h0, 1, 4'b0001, 2'd0, 1, 0);
      e_end = tbl.size();
      add("rs_first", 4'hF, 4'hF, 1, 4'b0001, 2'd0, 0, 0);
      add("rs_flush", 4'h0, 4'hF, 1, 4'b0000, 2'd1, 0, 0);
      f_end = tbl.size();

      // Reset with every requester asking: nothing may be granted.
      rst_n = 1'b0; req = 4'hF; in_last = 4'hF; out_ready = 1'b1;
      in_data_0 = '0; in_data_1 = '0; in_data_2 = '0; in_data_3 = '0;
      #3;
      check("rst.gnt",       32'(gnt),       32'd0);
      check("rst.nl_gnt",    32'(nl_gnt),    32'd0);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.out_data",  32'(out_data),  32'd0);
      check("rst.busy",      32'(busy),      32'd0);
      req = 4'h0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      run_range(0, a_end);
      run_range(a_end, b_end);

      // Backpressure: slot full, downstream stalled for four cycles.
      for (int i = 0; i < 4; i++) begin
         hv.name = "bp_hold"; hv.req = 4'hF; hv.last = 4'hF; hv.rdy = 1'b0;
         hv.gnt = 4'b0000; hv.sel = 2'd1; hv.busy = 1'b0; hv.nl = 1'b0;
         step(hv);
         check("bp_hold.out_valid", 32'(out_valid), 32'd1);
         check("bp_hold.out_data",  32'(out_data),  32'(exp_slot_data));
      end
      hv.name = "bp_release"; hv.rdy = 1'b1; hv.gnt = 4'b0010; hv.sel = 2'd1;
      step(hv);

      run_range(b_end, c_end);
      run_range(c_end, d_end);
      run_range(d_end, e_end);

      // Asynchronous reset while requester 0 owns the port.
      #2 rst_n = 1'b0;
      #1;
      check("mr.busy",      32'(busy),      32'd0);
      check("mr.out_valid", 32'(out_valid), 32'd0);
      check("mr.out_data",  32'(out_data),  32'd0);
      check("mr.gnt",       32'(gnt),       32'd0);
      sb.delete();
      req = 4'h0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      run_range(e_end, f_end);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/mux4_rr_sched.md
# mux4_rr_sched

Round-robin scheduler for a 4:1 flit mux on the router output path. It shares one output port among four requesters using a valid/grant handshake. Once a requester wins, it keeps the port until its packet's tail flit (optional), and the selected flit is registered into a one-entry output slot. The datapath is a bit-sliced array of `mux4to1` cells driven by this block's `sel`, so the scheduler owns sequencing and the cells stay purely combinational.

## Interface
Parameters:
- `DATA_W`, 16, flit width in bits.
- `LOCK_PKT`, 1. When 1, a winner holds the port until it sends a flit with `last`. When 0, every flit is arbitrated independently.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 4: per-requester flit valid.
- `in_data_0`..`in_data_3` in `DATA_W` each: per-requester flit.
- `in_last` in 4: per-requester tail-flit marker.
- `gnt` in/out: out, 4 bits. One-hot accept. A transfer from requester i happens in a cycle when `req[i] & gnt[i]`.
- `sel` out 2: index of the current winner; drives the `mux4to1` select.
- `out_valid` out 1: output slot holds a flit.
- `out_data` out `DATA_W`: registered flit.
- `out_last` out 1: registered tail marker.
- `out_ready` in 1: downstream accepts `out_data` this cycle.
- `busy` out 1: high in the LOCK state.

## Operation
- `can_acc = !out_valid | out_ready`. This is a one-entry pipeline slot that is refillable in the same cycle it drains.
- State machine has two states, IDLE and LOCK. Registers: `ptr[1:0]` (round-robin start), `owner[1:0]`.
- IDLE:
  - `winner` is the first i with `req[i]=1`, scanning `ptr`, `ptr+1`, … modulo 4.
  - If any `req` and `can_acc`, then `gnt[winner]=1`.
  - On transfer, load the slot and set `ptr <= winner+1` (mod 4, 2-bit wrap).
  - If `LOCK_PKT=1` and `in_last[winner]=0`, go to LOCK with `owner <= winner`.
- LOCK:
  - `winner = owner`. `gnt[owner] = req[owner] & can_acc`. All other `gnt` bits are 0, even if the owner is idle.
  - On a transfer with `in_last[owner]=1`, return to IDLE. `ptr` is already `owner+1`.
- `sel` equals `winner` in IDLE and `owner` in LOCK. When no request is pending in IDLE, `sel = ptr`.
- `gnt` is at most one-hot. It is never asserted when `!can_acc`.
- Slot update:
  - On a transfer: `out_valid<=1`, `out_data<=in_data_sel`, `out_last<=in_last[sel]`.
  - Else if `out_ready`: `out_valid<=0`. `out_data` and `out_last` hold their values.
  - Else: hold.
- With `LOCK_PKT=0` the block never enters LOCK, and `in_last` is only forwarded.
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `ptr=0`, `owner=0`, state=IDLE. Combinationally, `gnt=0` and `busy=0` during reset.
- Reset asserted mid-packet clears the lock and drops the slot contents. The upstream requester must also be reset.

## Timing
- `gnt` and `sel` are combinational from `req`, `out_ready`, and the registered state. They are valid in the same cycle; there is no registered grant.
- Latency from transfer edge to `out_valid` is 1 cycle.
- Throughput is 1 flit/cycle while `out_ready` is held high.
- Backpressure: `out_valid=1` with `out_ready=0` gives `gnt=0`. The slot, `ptr`, and state all hold.
- Fairness: each requester with a continuous request is granted within 3 other grants in IDLE, or within 3 other packets in LOCK.
- `ptr` wraps from 3 to 0.
- If the owner drops `req` in LOCK, the port idles; nothing is preempted.

## Structure
- Shared package holds `NUM_REQ=4`, `SEL_W=2`, state encoding `ST_IDLE=1'b0` / `ST_LOCK=1'b1`, and the default flit width.
- One sub-module: `rr_pick4`. It is a combinational 4-way rotating priority encoder: `req[3:0]` and `ptr[1:0]` in, `any` and `idx[1:0]` out.
- Datapath: a generate loop of `DATA_W` `mux4to1` instances plus one for `in_last`, all sharing `sel`.

## Test plan
- Reset: drive `rst_n=0` with `req=4'hF` → `gnt=0`, `out_valid=0`, `out_data=0`, `busy=0`. Release, `LOCK_PKT=0`, all `last=1`, `out_ready=1` → grants 0,1,2,3,0 on consecutive cycles; `out_data` follows one cycle later.
- Packet lock, `LOCK_PKT=1`:
  - Requester 2 sends 3 flits (last on the third) while `req=4'hF`.
  - Expect `gnt=4'b0100` for 3 transfers and `busy=1` after the first.
  - The next grant goes to 3, then 0.
- Backpressure: hold `out_ready=0` for 4 cycles with the slot full → `gnt=0`, `out_data` and `ptr` stable. Raise `out_ready` → a grant occurs the same cycle and the slot reloads with no bubble.
- Owner gap: in LOCK with owner 1, drop `req[1]` for 2 cycles while `req[0]`/`req[3]` are high → `gnt=0` for those 2 cycles, and the packet resumes on requester 1.
- Wrap and single requester:
  - `ptr=3`, `req=4'b0001` → `gnt=4'b0001`, `sel=0`, `ptr` becomes 1.
  - Isolated `req=4'b1000` → `sel=3`.
- Mid-packet reset: assert `rst_n=0` asynchronously in LOCK → `busy` and `out_valid` drop immediately. After release, arbitration restarts from `ptr=0`.
